// File: rtl/mul4_pkg.sv
// Shared types and sizes for the 4x4 sequential shift-add multiplier.
package mul4_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/add_sub.sv
// 4-bit adder/subtractor: S=0 gives a+b, S=1 gives a-b, as a 5-bit result.
module add_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       S,
  output logic [4:0] sum,
  output logic       cout
);

  always_comb begin
    sum = S ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  end

  assign cout = sum[4];

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier: four CALC cycles per product.
// Define ZERO_SKIP_EN to send zero-operand starts straight to DONE.
module mul4_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import mul4_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     s5;
  logic               unused_cout;
  logic               zero_op;
  logic               accept;
  logic               last_calc;

`ifdef ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_calc = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  add_sub u_add_sub (
    .a    (acc_q),
    .b    (m_q),
    .S    (1'b0),
    .sum  (sum),
    .cout (unused_cout)
  );

  assign s5 = q_q[0] ? sum : {1'b0, acc_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = zero_op ? DONE : CALC;
        else       state_d = IDLE;
      end
      CALC: begin
        if (last_calc) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  // Datapath: {acc,q} shifts right one place per CALC edge with the adder carry in.
  always_comb begin
    m_d    = m_q;
    q_d    = q_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (accept) begin
      m_d   = a;
      q_d   = b;
      acc_d = '0;
      cnt_d = '0;
      if (zero_op) prod_d = '0;
    end else if (state_q == CALC) begin
      acc_d = s5[WIDTH:1];
      q_d   = {s5[0], q_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last_calc) prod_d = {s5, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      q_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      m_q    <= m_d;
      q_q    <= q_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Self-checking bench for mul4_seq_ctrl: directed table, corner sequences, random ops.
module tb_mul4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  mul4_seq_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected CALC length for an operand pair, from the operating mode alone.
  function automatic int calc_cycles(input logic [3:0] ta, input logic [3:0] tb_);
    if (ZS && (ta == 4'd0 || tb_ == 4'd0)) return 0;
    return 4;
  endfunction

  // One operation: start for one cycle, scramble operands, check busy window and result.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp,
                        input string nm);
    int n;
    n = calc_cycles(ta, tb_);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      chk({nm, " busy"}, {14'd0, busy, done}, 16'b10);
      @(negedge clk);
    end
    chk({nm, " done"}, {14'd0, busy, done}, 16'b01);
    chk({nm, " product"}, {8'd0, product}, {8'd0, exp});
    @(negedge clk);
    chk({nm, " idle hold"}, {6'd0, busy, done, product}, {8'd0, exp});
  endtask

  initial begin
    logic [3:0] ra, rb;
    vecs[0] = '{a: 4'd9,  b: 4'd10, p: 8'h5A};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd1,  b: 4'd1,  p: 8'h01};
    vecs[3] = '{a: 4'd0,  b: 4'd7,  p: 8'h00};
    vecs[4] = '{a: 4'd12, b: 4'd11, p: 8'h84};
    vecs[5] = '{a: 4'd7,  b: 4'd0,  p: 8'h00};

    rst   = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    #3;
    chk("reset outputs", {6'd0, busy, done, product}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", {6'd0, busy, done, product}, 16'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // start pulsed during CALC with a=3,b=3 must be ignored
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ignore start busy", {14'd0, busy, done}, 16'b10);
      if (i == 1) begin start = 1'b1; a = 4'd3; b = 4'd3; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore start done", {14'd0, busy, done}, 16'b01);
    chk("ignore start product", {8'd0, product}, 16'd35);

    // back-to-back with start held: 9*6, 6*9, 8*8
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd6;
    @(negedge clk);
    a = 4'd6; b = 4'd9;
    for (int i = 0; i < 4; i++) begin
      chk("b2b op1 busy", {14'd0, busy, done}, 16'b10);
      @(negedge clk);
    end
    chk("b2b op1 done", {14'd0, busy, done}, 16'b01);
    chk("b2b op1 product", {8'd0, product}, 16'd54);
    @(negedge clk);
    a = 4'd8; b = 4'd8;
    for (int i = 0; i < 4; i++) begin
      chk("b2b op2 busy", {14'd0, busy, done}, 16'b10);
      @(negedge clk);
    end
    chk("b2b op2 done", {14'd0, busy, done}, 16'b01);
    chk("b2b op2 product", {8'd0, product}, 16'd54);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b op3 busy", {14'd0, busy, done}, 16'b10);
      @(negedge clk);
    end
    chk("b2b op3 done", {14'd0, busy, done}, 16'b01);
    chk("b2b op3 product", {8'd0, product}, 16'd64);

    // async reset at CALC cycle 2
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(negedge clk);
    start = 1'b0;
    chk("pre-reset busy", {14'd0, busy, done}, 16'b10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {6'd0, busy, done, product}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no done after reset", {6'd0, busy, done, product}, 16'd0);
    end
    run_op(4'd5, 4'd3, 8'd15, "post reset 5x3");

    // random operands against plain multiplication
    for (int i = 0; i < 25; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ra, rb, 8'(ra * rb), $sformatf("rand %0dx%0d", ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && busy && done) begin
      n_fail++;
      $display("FAIL busy_done_overlap: got busy=1 done=1 required not both high");
    end
  end

endmodule
